// File: rtl/issue_arbiter.sv
// issue_arbiter: per-cycle select logic for one issue queue bank.
// Picks at most one requesting slot by priority, breaks ties round-robin,
// and forces slots that have waited STARVE_LIMIT cycles to the front.
// The winning index is registered for the register-read stage.
module issue_arbiter #(
  parameter int N_SLOTS      = 8,
  parameter int WIDTH_IDX    = $clog2(N_SLOTS),
  parameter int WIDTH_PRY    = 2,
  parameter int WIDTH_STV    = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_SLOTS-1:0]             i_request,
  input  logic [N_SLOTS*WIDTH_PRY-1:0]   i_priority,
  input  logic                           i_fu_ready,
  input  logic                           i_flush,
  output logic [N_SLOTS-1:0]             o_grant,
  output logic [WIDTH_IDX-1:0]           o_grant_idx,
  output logic                           o_issue,
  output logic [WIDTH_IDX-1:0]           o_issue_idx,
  output logic                           o_starved
);

  localparam logic [WIDTH_STV-1:0] STV_MAX = WIDTH_STV'(STARVE_LIMIT);

  logic                                gen;
  logic [N_SLOTS-1:0][WIDTH_PRY-1:0]   pry;
  logic [WIDTH_PRY-1:0]                max_pry;
  logic [N_SLOTS-1:0]                  forced;
  logic [N_SLOTS-1:0]                  top_pry;
  logic [N_SLOTS-1:0]                  cand;
  logic [WIDTH_IDX-1:0]                rr_reg;
  logic [WIDTH_IDX-1:0]                scan_idx;
  logic [WIDTH_IDX-1:0]                win_idx;
  logic                                found;
  logic                                grant_any;
  logic                                issue_reg;
  logic [WIDTH_IDX-1:0]                issue_idx_reg;

  // A flush or a busy FU suppresses every grant in this cycle.
  assign gen = i_fu_ready & ~i_flush;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
      logic [WIDTH_STV-1:0] stv_reg;

      assign pry[gi]     = i_priority[gi*WIDTH_PRY +: WIDTH_PRY];
      assign forced[gi]  = i_request[gi] & (stv_reg == STV_MAX);
      assign top_pry[gi] = i_request[gi] & (pry[gi] == max_pry);

      // Starvation counter: counts cycles lost to arbitration, held while the FU stalls.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          stv_reg <= '0;
        end else if (!i_request[gi] || o_grant[gi] || i_flush) begin
          stv_reg <= '0;
        end else if (i_fu_ready && (stv_reg != STV_MAX)) begin
          stv_reg <= stv_reg + 1'b1;
        end
      end
    end
  endgenerate

  // Highest priority present among the requesting slots.
  always_comb begin
    max_pry = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (i_request[i] && (pry[i] > max_pry)) begin
        max_pry = pry[i];
      end
    end
  end

  // Forced slots override priority entirely.
  assign cand = (|forced) ? forced : top_pry;

  // Round-robin scan starting at rr; scanning downwards lets the lowest offset win.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      scan_idx = rr_reg + WIDTH_IDX'(k);
      if (cand[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  assign grant_any   = gen & found;
  assign o_grant     = grant_any ? (N_SLOTS'(1) << win_idx) : '0;
  assign o_grant_idx = grant_any ? win_idx : '0;
  assign o_starved   = grant_any & (|forced);

  // Round-robin pointer advances past the winner; index width gives the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_reg <= '0;
    end else if (grant_any) begin
      rr_reg <= win_idx + 1'b1;
    end
  end

  // Issue register feeding register-read; index holds when nothing issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      issue_reg     <= 1'b0;
      issue_idx_reg <= '0;
    end else begin
      issue_reg <= grant_any;
      if (grant_any) begin
        issue_idx_reg <= win_idx;
      end
    end
  end

  assign o_issue     = issue_reg;
  assign o_issue_idx = issue_idx_reg;

endmodule

// File: tb/tb_issue_arbiter.sv
// Self-checking bench for issue_arbiter (8 slots, 2-bit priority, limit 15).
// Expected grants and issues are queued as stimulus is driven and popped
// as the DUT produces them.
module tb_issue_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_request;
  logic [15:0] i_priority;
  logic        i_fu_ready;
  logic        i_flush;
  logic [7:0]  o_grant;
  logic [2:0]  o_grant_idx;
  logic        o_issue;
  logic [2:0]  o_issue_idx;
  logic        o_starved;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       starved;
  } grant_exp_t;

  typedef struct {
    logic       issue;
    logic [2:0] idx;
  } issue_exp_t;

  grant_exp_t gq[$];
  issue_exp_t iq[$];
  logic [2:0] last_idx;
  int n_checks;
  int n_errors;

  issue_arbiter #(
    .N_SLOTS(8), .WIDTH_IDX(3), .WIDTH_PRY(2), .WIDTH_STV(4), .STARVE_LIMIT(15)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_request(i_request), .i_priority(i_priority),
    .i_fu_ready(i_fu_ready), .i_flush(i_flush), .o_grant(o_grant),
    .o_grant_idx(o_grant_idx), .o_issue(o_issue), .o_issue_idx(o_issue_idx),
    .o_starved(o_starved)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs and queue what should come out (exp_idx < 0: no grant).
  task automatic drive(input logic [7:0] req, input logic [15:0] pry, input logic rdy,
                       input logic fl, input int exp_idx, input logic exp_st);
    grant_exp_t g;
    issue_exp_t ie;
    i_request  = req;
    i_priority = pry;
    i_fu_ready = rdy;
    i_flush    = fl;
    g.grant    = (exp_idx < 0) ? 8'h00 : (8'h01 << exp_idx);
    g.idx      = (exp_idx < 0) ? 3'd0 : exp_idx[2:0];
    g.starved  = exp_st;
    gq.push_back(g);
    if (exp_idx >= 0) last_idx = exp_idx[2:0];
    ie.issue = (exp_idx >= 0);
    ie.idx   = last_idx;
    iq.push_back(ie);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_request = '0; i_priority = '0; i_fu_ready = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n  = 1'b1;
    last_idx = 3'd0;
    gq.delete();
    iq.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_request = '0; i_priority = '0; i_fu_ready = 1'b1; i_flush = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_issue !== 1'b0 || o_issue_idx !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_issue: got %b/%0d want 0/0", o_issue, o_issue_idx);
    end
    n_checks++;
    if (o_grant !== 8'h00 || o_grant_idx !== 3'd0 || o_starved !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_grant: got %b/%0d/%b want 0/0/0", o_grant, o_grant_idx, o_starved);
    end
    $display("reset: grant=%b issue=%b issue_idx=%0d", o_grant, o_issue, o_issue_idx);
  endtask

  task automatic test_priority();
    grant_exp_t ge;
    issue_exp_t ie;
    int exp_seq[3] = '{5, 6, 5};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(8'h62, 16'h3C04, 1'b1, 1'b0, exp_seq[c], 1'b0);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL priority c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL priority c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("priority c%0d: grant_idx=%0d issue=%b/%0d", c, o_grant_idx, o_issue, o_issue_idx);
    end
  endtask

  task automatic test_rr_wrap();
    grant_exp_t ge;
    issue_exp_t ie;
    int exp_seq[5] = '{5, 6, 7, 0, 1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      // First cycle parks rr at 6 with a lone request on slot 5.
      drive((c == 0) ? 8'h20 : 8'hFF, 16'h0000, 1'b1, 1'b0, exp_seq[c], 1'b0);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL rr_wrap c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL rr_wrap c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("rr_wrap c%0d: grant=%b issue=%b/%0d", c, o_grant, o_issue, o_issue_idx);
    end
  endtask

  task automatic test_starvation();
    grant_exp_t ge;
    issue_exp_t ie;
    int e;
    logic s;
    do_reset();
    // Slot 2 wins only when forced: cycle 15, then again 16 cycles later.
    for (int c = 0; c < 32; c++) begin
      s = (c == 15) || (c == 31);
      e = s ? 2 : 3;
      drive(8'h0C, 16'h00C0, 1'b1, 1'b0, e, s);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL starve c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL starve c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("starve c%0d: grant_idx=%0d starved=%b issue=%b/%0d", c,
               o_grant_idx, o_starved, o_issue, o_issue_idx);
    end
  endtask

  task automatic test_stall();
    grant_exp_t ge;
    issue_exp_t ie;
    int e;
    logic rdy;
    logic s;
    do_reset();
    // 10 ready, 5 stalled, then slot 2 must need 5 more ready cycles before forcing.
    for (int c = 0; c < 21; c++) begin
      rdy = !(c >= 10 && c < 15);
      s   = (c == 20);
      e   = !rdy ? -1 : (s ? 2 : 3);
      drive(8'h0C, 16'h00C0, rdy, 1'b0, e, s);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL stall c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL stall c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("stall c%0d: ready=%b grant=%b starved=%b issue=%b/%0d", c,
               rdy, o_grant, o_starved, o_issue, o_issue_idx);
    end
  endtask

  task automatic test_flush();
    grant_exp_t ge;
    issue_exp_t ie;
    int e;
    logic fl;
    logic s;
    int pre_seq[3]  = '{5, 6, 7};
    int post_seq[3] = '{6, 7, 5};
    do_reset();
    // 10 cycles bring slot 4 to stv=10 and rr to 6; cycle 10 flushes.
    for (int c = 0; c < 28; c++) begin
      fl = (c == 10);
      s  = (c == 26);
      if (c < 10)       e = pre_seq[c % 3];
      else if (fl)      e = -1;
      else if (s)       e = 4;
      else if (c == 27) e = 5;
      else              e = post_seq[(c - 11) % 3];
      drive(8'hF0, 16'hFC00, 1'b1, fl, e, s);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL flush c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL flush c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("flush c%0d: flush=%b grant=%b starved=%b issue=%b/%0d", c,
               fl, o_grant, o_starved, o_issue, o_issue_idx);
    end
  endtask

  task automatic test_async_reset();
    grant_exp_t ge;
    issue_exp_t ie;
    int exp_seq[5] = '{0, 1, 2, 0, 1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c == 3) begin
        n_checks++;
        if (o_issue !== 1'b1 || o_issue_idx !== 3'd2) begin
          n_errors++;
          $display("FAIL async_pre: got %b/%0d want 1/2", o_issue, o_issue_idx);
        end
        // Drop reset between edges; slots clear val under reset.
        #3;
        i_rst_n   = 1'b0;
        i_request = 8'h00;
        #1;
        n_checks++;
        if (o_issue !== 1'b0 || o_issue_idx !== 3'd0 || o_grant !== 8'h00) begin
          n_errors++;
          $display("FAIL async_during: got issue=%b/%0d grant=%b want 0/0/0",
                   o_issue, o_issue_idx, o_grant);
        end
        $display("async: reset asserted mid-cycle issue=%b/%0d", o_issue, o_issue_idx);
        @(posedge i_clk); #1;
        i_rst_n  = 1'b1;
        last_idx = 3'd0;
      end
      drive(8'hFF, 16'h0000, 1'b1, 1'b0, exp_seq[c], 1'b0);
      @(negedge i_clk);
      ge = gq.pop_front();
      n_checks++;
      if (o_grant !== ge.grant || o_grant_idx !== ge.idx || o_starved !== ge.starved) begin
        n_errors++;
        $display("FAIL async c%0d grant: got %b/%0d/%b want %b/%0d/%b", c,
                 o_grant, o_grant_idx, o_starved, ge.grant, ge.idx, ge.starved);
      end
      @(posedge i_clk); #1;
      ie = iq.pop_front();
      n_checks++;
      if (o_issue !== ie.issue || o_issue_idx !== ie.idx) begin
        n_errors++;
        $display("FAIL async c%0d issue: got %b/%0d want %b/%0d", c,
                 o_issue, o_issue_idx, ie.issue, ie.idx);
      end
      $display("async c%0d: grant_idx=%0d issue=%b/%0d", c, o_grant_idx, o_issue, o_issue_idx);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    last_idx   = 3'd0;
    i_rst_n    = 1'b0;
    i_request  = '0;
    i_priority = '0;
    i_fu_ready = 1'b0;
    i_flush    = 1'b0;
    test_reset();
    test_priority();
    test_rr_wrap();
    test_starvation();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
